// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and IF/ID register.
// Widths, reset/NOP encodings, next-PC source codes and the address alignment helper.
package if_id_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_INCR       = 32'h0000_0004;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_HOLD   = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Instruction addresses are word aligned; low two bits never reach the PC.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of redirect/hazard controls, instruction-memory read data and IF/ID outputs.
// The slave side is the fetch stage; the master side is the surrounding pipeline.
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic               stall;
    logic               Jump;
    logic [ADDR_W-1:0]  jump_target;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               IF_ID_Flush;
    logic [INSTR_W-1:0] imem_rdata;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  IF_ID_PC;
    logic [ADDR_W-1:0]  IF_ID_PC_plus4;
    logic [INSTR_W-1:0] IF_ID_Instr;
    logic               IF_ID_Valid;

    modport master (
        output stall, Jump, jump_target, branch_taken, branch_target, IF_ID_Flush, imem_rdata,
        input  pc, IF_ID_PC, IF_ID_PC_plus4, IF_ID_Instr, IF_ID_Valid
    );

    modport slave (
        input  stall, Jump, jump_target, branch_taken, branch_target, IF_ID_Flush, imem_rdata,
        output pc, IF_ID_PC, IF_ID_PC_plus4, IF_ID_Instr, IF_ID_Valid
    );

endinterface

// File: rtl/if_id_stage_chk.sv
// Property checker for the fetch stage outputs: word-aligned PC, and bubbles carry the NOP word.
module if_id_stage_chk
    import if_id_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input logic               clk,
    input logic               reset,
    input logic [ADDR_W-1:0]  pc,
    input logic               if_id_valid,
    input logic [INSTR_W-1:0] if_id_instr
);

    a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
        pc[1:0] == 2'b00);

    a_bubble_is_nop: assert property (@(posedge clk) disable iff (reset)
        !if_id_valid |-> (if_id_instr == NOP_INSTR));

endmodule

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with next-PC priority: EX branch, then ID jump (only when not stalled),
// then stall hold, then sequential. Redirect targets are word-aligned before use.
module if_id_stage_pc_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    pc_sel_e           pc_sel_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_r;

    // Next-PC source selection; a taken branch squashes any jump sitting in ID.
    always_comb begin
        pc_sel_s = PC_SEQ;
        if (branch_taken) begin
            pc_sel_s = PC_BRANCH;
        end else if (jump && !stall) begin
            pc_sel_s = PC_JUMP;
        end else if (stall) begin
            pc_sel_s = PC_HOLD;
        end else begin
            pc_sel_s = PC_SEQ;
        end
    end

    // Next-PC value mux.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_BRANCH: pc_next_s = align_addr(branch_target);
            PC_JUMP:   pc_next_s = align_addr(jump_target);
            PC_HOLD:   pc_next_s = pc_r;
            PC_SEQ:    pc_next_s = pc_r + PC_INCR;
            default:   pc_next_s = pc_r;
        endcase
    end

    // PC register; redirects only ever take effect through this flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= align_addr(RESET_PC);
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc       = pc_r;
    assign pc_plus4 = pc_r + PC_INCR;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register of the 5-stage CPU.
// Optional macro IF_ID_PERF_COUNTERS_EN adds flush_count / stall_count outputs.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    if_id_stage_if.slave bus
`ifdef IF_ID_PERF_COUNTERS_EN
    ,
    output logic [31:0] flush_count,
    output logic [31:0] stall_count
`endif
);

    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] pc_plus4_s;
    if_id_t            if_id_next_s;
    if_id_t            if_id_r;

    if_id_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (bus.stall),
        .jump          (bus.Jump),
        .jump_target   (bus.jump_target),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .pc            (pc_s),
        .pc_plus4      (pc_plus4_s)
    );

    // IF/ID next value; a flush still records the PC so the bubble carries its address.
    always_comb begin
        if_id_next_s = if_id_r;
        if (bus.IF_ID_Flush) begin
            if_id_next_s.instr    = NOP_INSTR;
            if_id_next_s.valid    = 1'b0;
            if_id_next_s.pc       = pc_s;
            if_id_next_s.pc_plus4 = pc_plus4_s;
        end else if (bus.stall) begin
            if_id_next_s = if_id_r;
        end else begin
            if_id_next_s.instr    = bus.imem_rdata;
            if_id_next_s.valid    = 1'b1;
            if_id_next_s.pc       = pc_s;
            if_id_next_s.pc_plus4 = pc_plus4_s;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_r.pc       <= 32'h0000_0000;
            if_id_r.pc_plus4 <= 32'h0000_0000;
            if_id_r.instr    <= NOP_INSTR;
            if_id_r.valid    <= 1'b0;
        end else begin
            if_id_r <= if_id_next_s;
        end
    end

    assign bus.pc             = pc_s;
    assign bus.IF_ID_PC       = if_id_r.pc;
    assign bus.IF_ID_PC_plus4 = if_id_r.pc_plus4;
    assign bus.IF_ID_Instr    = if_id_r.instr;
    assign bus.IF_ID_Valid    = if_id_r.valid;

`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] flush_cnt_r;
    logic [31:0] stall_cnt_r;

    // Hazard event counters; a stall masked by a flush is counted only as a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 32'h0000_0000;
        end else if (bus.IF_ID_Flush) begin
            flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
        end else if (bus.stall) begin
            stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
        end else begin
            flush_cnt_r <= flush_cnt_r;
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign flush_count = flush_cnt_r;
    assign stall_count = stall_cnt_r;
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: spec-level model compared every negedge plus directed literals.
module tb_if_id_stage;
    logic clk;
    logic reset;
    logic cmp_en;
    int   checks;
    int   errors;

    if_id_stage_if bus ();

`ifdef IF_ID_PERF_COUNTERS_EN
    logic [31:0] flush_count;
    logic [31:0] stall_count;
`endif

    if_id_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IF_ID_PERF_COUNTERS_EN
        ,
        .flush_count (flush_count),
        .stall_count (stall_count)
`endif
    );

    if_id_stage_chk #(.NOP_INSTR (32'h0000_0000)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .pc          (bus.pc),
        .if_id_valid (bus.IF_ID_Valid),
        .if_id_instr (bus.IF_ID_Instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, address-derived words elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2008_0005;
        return 32'hA000_0000 ^ a;
    endfunction

    always_comb bus.imem_rdata = mem(bus.pc);

    // Reference model state.
    logic [31:0] m_pc, m_ifpc, m_plus4, m_instr, m_fc, m_sc;
    logic        m_valid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'h0; m_ifpc <= 32'h0; m_plus4 <= 32'h0;
            m_instr <= 32'h0; m_valid <= 1'b0; m_fc <= 32'h0; m_sc <= 32'h0;
        end else begin
            if (bus.IF_ID_Flush) begin
                m_instr <= 32'h0; m_valid <= 1'b0; m_ifpc <= m_pc; m_plus4 <= m_pc + 32'd4;
                m_fc <= m_fc + 32'd1;
            end else if (bus.stall) begin
                m_sc <= m_sc + 32'd1;
            end else begin
                m_instr <= mem(m_pc); m_valid <= 1'b1; m_ifpc <= m_pc; m_plus4 <= m_pc + 32'd4;
            end
            if (bus.branch_taken)             m_pc <= bus.branch_target & 32'hFFFF_FFFC;
            else if (bus.Jump && !bus.stall)  m_pc <= bus.jump_target & 32'hFFFF_FFFC;
            else if (!bus.stall)              m_pc <= m_pc + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", bus.pc, m_pc);
            chk("if_id_pc", bus.IF_ID_PC, m_ifpc);
            chk("if_id_pc_plus4", bus.IF_ID_PC_plus4, m_plus4);
            chk("if_id_instr", bus.IF_ID_Instr, m_instr);
            chk("if_id_valid", {31'd0, bus.IF_ID_Valid}, {31'd0, m_valid});
`ifdef IF_ID_PERF_COUNTERS_EN
            chk("flush_count", flush_count, m_fc);
            chk("stall_count", stall_count, m_sc);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic st, input logic j, input logic [31:0] jt,
                       input logic bt, input logic [31:0] btg, input logic fl);
        bus.stall = st; bus.Jump = j; bus.jump_target = jt;
        bus.branch_taken = bt; bus.branch_target = btg; bus.IF_ID_Flush = fl;
    endtask

    initial begin
        checks = 0; errors = 0; cmp_en = 1'b0;
        reset = 1'b1;
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        cmp_en = 1'b1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_instr", bus.IF_ID_Instr, 32'h0);
        chk("rst_valid", {31'd0, bus.IF_ID_Valid}, 32'h0);
        @(negedge clk); reset = 1'b0;

        // 1: first fetch
        cyc();
        chk("t1_pc", bus.pc, 32'h4);
        chk("t1_instr", bus.IF_ID_Instr, 32'h2008_0005);
        chk("t1_ifpc", bus.IF_ID_PC, 32'h0);
        chk("t1_plus4", bus.IF_ID_PC_plus4, 32'h4);
        chk("t1_valid", {31'd0, bus.IF_ID_Valid}, 32'h1);
        cyc();
        // 2: stall two cycles at pc=8
        ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(); cyc();
        chk("t2_pc_hold", bus.pc, 32'h8);
        chk("t2_ifpc_hold", bus.IF_ID_PC, 32'h4);
        chk("t2_instr_hold", bus.IF_ID_Instr, 32'hA000_0004);
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("t2_pc_release", bus.pc, 32'hC);
        cyc();
        // 3: jump with flush at pc=16
        ctl(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        cyc();
        chk("t3_pc", bus.pc, 32'h40);
        chk("t3_valid", {31'd0, bus.IF_ID_Valid}, 32'h0);
        chk("t3_ifpc", bus.IF_ID_PC, 32'h10);
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("t3_fetch_valid", {31'd0, bus.IF_ID_Valid}, 32'h1);
        chk("t3_fetch_instr", bus.IF_ID_Instr, 32'hA000_0040);
        // 4: branch beats jump, stall and flush-together
        ctl(1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1);
        cyc();
        chk("t4_pc", bus.pc, 32'h100);
        chk("t4_valid", {31'd0, bus.IF_ID_Valid}, 32'h0);
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        // alignment masking and wrap
        ctl(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0207, 1'b0);
        cyc();
        chk("mask_branch", bus.pc, 32'h204);
        ctl(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("mask_jump", bus.pc, 32'hFFFF_FFFC);
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_plus4", bus.IF_ID_PC_plus4, 32'h0);
        // 5: jump held off by stall
        ctl(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        cyc();
        chk("t5_pc_hold", bus.pc, 32'h0);
        bus.stall = 1'b0;
        cyc();
        chk("t5_pc_jump", bus.pc, 32'h80);
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        // 6: asynchronous reset mid-cycle
        #1 reset = 1'b1;
        #1;
        chk("t6_pc", bus.pc, 32'h0);
        chk("t6_valid", {31'd0, bus.IF_ID_Valid}, 32'h0);
        chk("t6_instr", bus.IF_ID_Instr, 32'h0);
        #1 reset = 1'b0;
        cyc();
        chk("t6_refetch", bus.IF_ID_Instr, 32'h2008_0005);
        // counters: 3 flushes then 2 stalls
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(); cyc(); cyc();
        ctl(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(); cyc();
        ctl(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef IF_ID_PERF_COUNTERS_EN
        chk("flush_count_lit", flush_count, 32'd3);
        chk("stall_count_lit", stall_count, 32'd2);
`endif
        cyc(); cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
